addsub_pipe_2s: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the ALU execute path. Splits a WIDTH-bit operation into SEG_W-bit segments, each resolved in its own pipeline stage with a registered inter-stage carry. The result and the N/Z/C/V flags emerge aligned after a fixed latency. A valid/ready handshake with backpressure and a tag passthrough let it sit between the ID/EX and EX/MEM stages of the pipelined datapath.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/addsub_pipe_2s_if.sv | 47 ++++
 rtl/addsub_seg.sv | 23 ++
 rtl/addsub_pipe_2s.sv | 188 ++++++++++++++++++
 tb/tb_addsub_pipe_2s.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, the N/Z/C/V flag record and
// the bit positions of each flag inside the packed 4-bit flag word.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Packed so that a flags_t is exactly the 4-bit {N, Z, C, V} word.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic flags_t make_flags(input logic n, input logic z,
                                        input logic c, input logic v);
    flags_t f;
    f.n = n;
    f.z = z;
    f.c = c;
    f.v = v;
    return f;
  endfunction

endpackage

// File: rtl/addsub_pipe_2s_if.sv
// Operand/result bus of the pipelined adder/subtractor.
// The in_sat lane only exists when ADDSUB_SAT_EN is defined.
//
// Handshake: on both sides a beat transfers on a rising edge where
// valid && ready are both high. A producer holds valid and its payload
// stable until that edge; ready may be high without valid (no transfer).
interface addsub_pipe_2s_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
`ifdef ADDSUB_SAT_EN
  logic             in_sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

`ifdef ADDSUB_SAT_EN
  modport master (
    output in_valid, in_x, in_y, in_sub, in_tag, in_sat, out_ready,
    input  in_ready, out_valid, out_s, out_flags, out_tag
  );
  modport slave (
    input  in_valid, in_x, in_y, in_sub, in_tag, in_sat, out_ready,
    output in_ready, out_valid, out_s, out_flags, out_tag
  );
`else
  modport master (
    output in_valid, in_x, in_y, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_s, out_flags, out_tag
  );
  modport slave (
    input  in_valid, in_x, in_y, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_s, out_flags, out_tag
  );
`endif

endinterface

// File: rtl/addsub_seg.sv
// One SEG_W-bit ripple segment of the adder. Purely combinational; also
// reports the carry entering its top bit so the final segment can form V.
module addsub_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] x,
  input  logic [SEG_W-1:0] y,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SEG_W:0] sum;

  assign sum      = {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, cin};
  assign s        = sum[SEG_W-1:0];
  assign cout     = sum[SEG_W];
  // Sum bit = x ^ y ^ carry_in, so the carry into the top bit is recovered
  // from the top sum bit.
  assign c_msb_in = s[SEG_W-1] ^ x[SEG_W-1] ^ y[SEG_W-1];

endmodule

// File: rtl/addsub_pipe_2s.sv
// Pipelined two's-complement adder/subtractor.
// WIDTH bits are resolved SEG_W bits per stage over STAGES = WIDTH/SEG_W
// stages, then a result register forms N/Z/C/V. Latency is STAGES cycles.
// Whole pipe stalls while a result is presented and not taken.
// Optional feature: define ADDSUB_SAT_EN to add per-beat saturation (in_sat).
module addsub_pipe_2s
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst,
  addsub_pipe_2s_if.slave bus
);

  localparam int STAGES = WIDTH / SEG_W;
  localparam int LAST   = STAGES - 1;

  // Everything advances together; the pipe only freezes when the result
  // register holds a beat the consumer has not taken yet.
  logic adv;

  // Stage registers: operand copies travel forward so later stages can
  // pick their segment; s_q accumulates the already-resolved sum bits.
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] x_q     [STAGES];
  logic [WIDTH-1:0] y_q     [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic             c_q     [STAGES];
  logic             cmsb_q  [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];
`ifdef ADDSUB_SAT_EN
  logic             sat_q   [STAGES];
  logic             sat_src [STAGES];
`endif

  // Per-stage sources (bus for stage 0, previous stage otherwise).
  logic             v_src    [STAGES];
  logic [WIDTH-1:0] x_src    [STAGES];
  logic [WIDTH-1:0] y_src    [STAGES];
  logic [TAG_W-1:0] tag_src  [STAGES];
  logic [WIDTH-1:0] s_base   [STAGES];
  logic [WIDTH-1:0] s_ins    [STAGES];
  logic [SEG_W-1:0] seg_x    [STAGES];
  logic [SEG_W-1:0] seg_y    [STAGES];
  logic             seg_cin  [STAGES];
  logic [SEG_W-1:0] seg_s    [STAGES];
  logic             seg_cout [STAGES];
  logic             seg_cmsb [STAGES];

  // Y is inverted once on entry for subtraction; carry-in supplies the +1.
  logic [WIDTH-1:0] y_eff_in;
  assign y_eff_in = bus.in_y ^ {WIDTH{bus.in_sub == OP_SUB}};

  logic             out_valid_q;
  logic [WIDTH-1:0] out_s_q;
  flags_t           out_flags_q;
  logic [TAG_W-1:0] out_tag_q;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_src[k]   = bus.in_valid;
      assign x_src[k]   = bus.in_x;
      assign y_src[k]   = y_eff_in;
      assign tag_src[k] = bus.in_tag;
      assign s_base[k]  = '0;
      assign seg_x[k]   = bus.in_x[SEG_W-1:0];
      assign seg_y[k]   = y_eff_in[SEG_W-1:0];
      assign seg_cin[k] = bus.in_sub;
`ifdef ADDSUB_SAT_EN
      assign sat_src[k] = bus.in_sat;
`endif
    end else begin : g_body
      assign v_src[k]   = valid_q[k-1];
      assign x_src[k]   = x_q[k-1];
      assign y_src[k]   = y_q[k-1];
      assign tag_src[k] = tag_q[k-1];
      assign s_base[k]  = s_q[k-1];
      assign seg_x[k]   = x_q[k-1][k*SEG_W +: SEG_W];
      assign seg_y[k]   = y_q[k-1][k*SEG_W +: SEG_W];
      assign seg_cin[k] = c_q[k-1];
`ifdef ADDSUB_SAT_EN
      assign sat_src[k] = sat_q[k-1];
`endif
    end

    addsub_seg #(.SEG_W(SEG_W)) u_seg (
      .x        (seg_x[k]),
      .y        (seg_y[k]),
      .cin      (seg_cin[k]),
      .s        (seg_s[k]),
      .cout     (seg_cout[k]),
      .c_msb_in (seg_cmsb[k])
    );
  end

  // Merge each stage's freshly resolved segment into the travelling sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_ins[k] = s_base[k];
      s_ins[k][k*SEG_W +: SEG_W] = seg_s[k];
    end
  end

  // Stage registers: shift one place per advancing cycle, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
        cmsb_q[k]  <= 1'b0;
        tag_q[k]   <= '0;
`ifdef ADDSUB_SAT_EN
        sat_q[k]   <= 1'b0;
`endif
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= v_src[k];
        x_q[k]     <= x_src[k];
        y_q[k]     <= y_src[k];
        s_q[k]     <= s_ins[k];
        c_q[k]     <= seg_cout[k];
        cmsb_q[k]  <= seg_cmsb[k];
        tag_q[k]   <= tag_src[k];
`ifdef ADDSUB_SAT_EN
        sat_q[k]   <= sat_src[k];
`endif
      end
    end
  end

  // Final result and flags. C/V come from the raw wrapped add; N/Z look
  // at the value actually delivered (post-saturation when enabled).
  logic             raw_v;
  logic [WIDTH-1:0] res;
  flags_t           flags_d;

  assign raw_v = cmsb_q[LAST] ^ c_q[LAST];

`ifdef ADDSUB_SAT_EN
  // Overflow direction follows the sign of X: positive overflow is only
  // possible with X non-negative, negative overflow only with X negative.
  always_comb begin
    res = s_q[LAST];
    if (sat_q[LAST] && raw_v) begin
      res = x_q[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res = s_q[LAST];
`endif

  assign flags_d = make_flags(res[WIDTH-1], res == '0, c_q[LAST], raw_v);

  // Result register: loads on advance; payload only changes with a real
  // beat so the presented result stays put while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_flags_q <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      out_valid_q <= valid_q[LAST];
      if (valid_q[LAST]) begin
        out_s_q     <= res;
        out_flags_q <= flags_d;
        out_tag_q   <= tag_q[LAST];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_s     = out_s_q;
  assign bus.out_flags = out_flags_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_addsub_pipe_2s.sv
// Bench for addsub_pipe_2s (WIDTH=16, SEG_W=4). Works with or without
// ADDSUB_SAT_EN defined.
module tb_addsub_pipe_2s;
  import alu_pkg::*;

  localparam int WIDTH  = 16;
  localparam int SEG_W  = 4;
  localparam int TAG_W  = 5;
  localparam int STAGES = WIDTH / SEG_W;
  localparam int EW     = TAG_W + 4 + WIDTH;

`ifdef ADDSUB_SAT_EN
  localparam logic [15:0] S_V1 = 16'h7FFF;
  localparam logic [3:0]  F_V1 = 4'b0001;
  localparam logic [15:0] S_V3 = 16'h8000;
  localparam logic [3:0]  F_V3 = 4'b1011;
`else
  localparam logic [15:0] S_V1 = 16'h8000;
  localparam logic [3:0]  F_V1 = 4'b1001;
  localparam logic [15:0] S_V3 = 16'h7FFF;
  localparam logic [3:0]  F_V3 = 4'b0011;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addsub_pipe_2s_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  addsub_pipe_2s #(.WIDTH(WIDTH), .SEG_W(SEG_W), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  int bp_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic sub,
                                          input logic [TAG_W-1:0] tag,
                                          input logic sat);
    longint ux, uy, full, sx, sy, exact, maxs, mins;
    logic [WIDTH-1:0] s;
    logic n, z, c, v;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    maxs = (longint'(1) << (WIDTH - 1)) - 1;
    mins = -(longint'(1) << (WIDTH - 1));
    if (sub) begin
      full  = ux + ((longint'(1) << WIDTH) - 1 - uy) + 1;
      exact = sx - sy;
    end else begin
      full  = ux + uy;
      exact = sx + sy;
    end
    c = full[WIDTH];
    s = full[WIDTH-1:0];
    v = (exact > maxs) || (exact < mins);
    if (sat && v) s = (exact > 0) ? 16'h7FFF : 16'h8000;
    n = s[WIDTH-1];
    z = (s == '0);
    return {tag, n, z, c, v, s};
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  // Each negedge: compare the presented result with the oldest expected
  // one (repeatedly while stalled), retire it if taken, and enqueue the
  // model result for a beat about to be accepted.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check("result", {bus.out_tag, bus.out_flags, bus.out_s}, exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_x, bus.in_y, bus.in_sub, bus.in_tag,
`ifdef ADDSUB_SAT_EN
                              bus.in_sat
`else
                              1'b0
`endif
                              ));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic sub, input logic [TAG_W-1:0] tag,
                      input logic sat);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_sub   = sub;
    bus.in_tag   = tag;
`ifdef ADDSUB_SAT_EN
    bus.in_sat   = sat;
`endif
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [15:0] x,
                          input logic [15:0] y, input logic sub,
                          input logic [TAG_W-1:0] tag, input logic sat,
                          input logic [15:0] es, input logic [3:0] ef);
    int lat = -1;
    send(x, y, sub, tag, sat);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i - 1;
        break;
      end
    end
    check({name, "_latency"}, lat, STAGES);
    check({name, "_s"}, bus.out_s, es);
    check({name, "_flags"}, bus.out_flags, ef);
    check({name, "_tag"}, bus.out_tag, tag);
    drain();
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_sub   = 1'b0;
    bus.in_tag   = '0;
`ifdef ADDSUB_SAT_EN
    bus.in_sat   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_s", bus.out_s, 0);
    check("rst_out_flags", bus.out_flags, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Boundary vectors.
    directed("max_plus_one", 16'h7FFF, 16'h0001, OP_ADD, 5'd1, 1'b1, S_V1, F_V1);
    directed("equal_sub",    16'h0005, 16'h0005, OP_SUB, 5'd2, 1'b0, 16'h0000, 4'b0110);
    directed("min_minus_one",16'h8000, 16'h0001, OP_SUB, 5'd3, 1'b1, S_V3, F_V3);
    directed("full_ripple",  16'hFFFF, 16'h0001, OP_ADD, 5'd4, 1'b0, 16'h0000, 4'b0110);

    // Backpressure: six back-to-back beats, a 3-cycle stall once results flow.
    fork
      begin
        for (int t = 1; t <= 6; t++)
          send(16'(t * 16'h1111), 16'(t * 3), t[0], 5'(t), 1'b0);
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            seen = 1;
            break;
          end
        end
        check("bp_first_out", seen, 1);
        @(posedge clk);
        #1;
        bp_mode = 2;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_stall_in_ready", bus.in_ready, 0);
          check("bp_stall_out_valid", bus.out_valid, 1);
        end
        @(posedge clk);
        #1;
        bp_mode = 0;
      end
    join
    drain();

    // Reset with three beats in flight: none may emerge.
    send(16'h1234, 16'h0101, OP_ADD, 5'd10, 1'b0);
    send(16'h2345, 16'h0202, OP_SUB, 5'd11, 1'b0);
    send(16'h3456, 16'h0303, OP_ADD, 5'd12, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 1);
    for (int i = 0; i < STAGES + 3; i++) begin
      check("flush_quiet", bus.out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // Randomised traffic with random gaps and random backpressure.
    bp_mode = 1;
    for (int b = 0; b < 250; b++) begin
      int gap;
      gap = $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
           TAG_W'($urandom), 1'($urandom_range(0, 1)));
    end
    bp_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
